// File: rtl/sequence_packer.sv
// Purpose: clamps each sequence step to its stored field widths, packs it into a 128-bit sequence word and writes consecutive buffer addresses.
// Latency: a handshake at edge N gives wr_en with that word from edge N+2 (clamp stage, pack stage, write register).
// Backpressure: s_ready is high for the whole RUN state; the write port never stalls, so one step per cycle is accepted.
module sequence_packer #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_steps,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_dac_0,
  input  logic [15:0]       s_dac_1,
  input  logic [15:0]       s_pdm_0,
  input  logic [15:0]       s_pdm_1,
  input  logic [15:0]       s_pdm_2,
  input  logic [15:0]       s_pdm_3,
  input  logic [1:0]        s_enable_dac,
  input  logic [1:0]        s_resync_dac,
  input  logic [3:0]        s_enable_pdm,
  input  logic [1:0]        s_ramp_down,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [127:0]      wr_data,
  output logic              busy,
  output logic              done,
  output logic [5:0]        sat_flags
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic   start_acc;
  logic   hs;
  logic   acc_en;
  logic   last_step;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   num_q;
  logic [ADDR_W:0]   acc_cnt_q;
  logic [ADDR_W:0]   acc_cnt_nxt;
  logic [ADDR_W-1:0] wr_idx_q;
  logic [5:0]        sat_flags_q;
  logic [5:0]        sat_now;

  // Stage 1: clamped fields
  logic             s1_vld_q;
  logic [13:0]      s1_dac0_q, s1_dac1_q, s1_dac0_d, s1_dac1_d;
  logic [3:0][10:0] s1_pdm_q, s1_pdm_d;
  logic [1:0]       s1_en_dac_q, s1_resync_q, s1_ramp_q;
  logic [3:0]       s1_en_pdm_q;

  // Stage 2: packed word
  logic         s2_vld_q;
  logic [127:0] s2_word_q, s2_word_d;

  // Write port register
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [127:0]      wr_data_q;

  // A DAC value fits 14-bit two's complement when its top three bits agree.
  function automatic logic dac_sat(input logic [15:0] v);
    return (v[15:13] != 3'b000) && (v[15:13] != 3'b111);
  endfunction

  function automatic logic [13:0] clamp_dac(input logic [15:0] v);
    logic [13:0] r;
    if (!dac_sat(v)) r = v[13:0];
    else if (v[15])  r = 14'h2000;
    else             r = 14'h1FFF;
    return r;
  endfunction

  function automatic logic [10:0] clamp_pdm(input logic [15:0] v);
    return (|v[15:11]) ? 11'h7FF : v[10:0];
  endfunction

  assign hs          = s_valid & s_ready;
  assign acc_en      = hs & ~abort;
  assign acc_cnt_nxt = acc_cnt_q + CNT_ONE;
  assign last_step   = (acc_cnt_nxt == num_q);

  assign s_ready   = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign sat_flags = sat_flags_q;

  // Clamp the incoming step and flag which fields were out of range.
  always_comb begin
    s1_dac0_d   = clamp_dac(s_dac_0);
    s1_dac1_d   = clamp_dac(s_dac_1);
    s1_pdm_d[0] = clamp_pdm(s_pdm_0);
    s1_pdm_d[1] = clamp_pdm(s_pdm_1);
    s1_pdm_d[2] = clamp_pdm(s_pdm_2);
    s1_pdm_d[3] = clamp_pdm(s_pdm_3);
    sat_now     = {|s_pdm_3[15:11], |s_pdm_2[15:11], |s_pdm_1[15:11], |s_pdm_0[15:11],
                   dac_sat(s_dac_1), dac_sat(s_dac_0)};
  end

  // Pack stage-1 fields into the sequence word layout; unlisted bits stay zero.
  always_comb begin
    s2_word_d           = '0;
    s2_word_d[13:0]     = s1_dac0_q;
    s2_word_d[29:16]    = s1_dac1_q;
    s2_word_d[31:30]    = s1_resync_q;
    s2_word_d[42:32]    = s1_pdm_q[0];
    s2_word_d[58:48]    = s1_pdm_q[1];
    s2_word_d[74:64]    = s1_pdm_q[2];
    s2_word_d[90:80]    = s1_pdm_q[3];
    s2_word_d[97:96]    = s1_en_dac_q;
    s2_word_d[101:98]   = s1_en_pdm_q;
    s2_word_d[113:112]  = s1_ramp_q;
  end

  // Next-state logic; abort overrides everything including a same-cycle start.
  // A zero-length burst passes through DRAIN (pipeline already empty) so done lands one cycle after start.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start) begin
          start_acc = 1'b1;
          state_d   = (num_steps == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (hs && last_step) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_vld_q && !s2_vld_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      start_acc = 1'b0;
    end
  end

  // State, burst parameters, counters and sticky saturation flags.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      acc_cnt_q   <= '0;
      wr_idx_q    <= '0;
      sat_flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        base_q      <= base_addr;
        num_q       <= num_steps;
        acc_cnt_q   <= '0;
        wr_idx_q    <= '0;
        sat_flags_q <= '0;
      end else begin
        if (acc_en) begin
          acc_cnt_q   <= acc_cnt_nxt;
          sat_flags_q <= sat_flags_q | sat_now;
        end
        if (s2_vld_q && !abort) wr_idx_q <= wr_idx_q + IDX_ONE;
      end
    end
  end

  // Three-register datapath: clamp, pack, write; abort empties every valid bit at once.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s1_vld_q    <= 1'b0;
      s1_dac0_q   <= '0;
      s1_dac1_q   <= '0;
      s1_pdm_q    <= '0;
      s1_en_dac_q <= '0;
      s1_resync_q <= '0;
      s1_en_pdm_q <= '0;
      s1_ramp_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_word_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      s1_vld_q <= acc_en;
      if (acc_en) begin
        s1_dac0_q   <= s1_dac0_d;
        s1_dac1_q   <= s1_dac1_d;
        s1_pdm_q    <= s1_pdm_d;
        s1_en_dac_q <= s_enable_dac;
        s1_resync_q <= s_resync_dac;
        s1_en_pdm_q <= s_enable_pdm;
        s1_ramp_q   <= s_ramp_down;
      end
      s2_vld_q <= s1_vld_q & ~abort;
      if (s1_vld_q) s2_word_q <= s2_word_d;
      wr_en_q <= s2_vld_q & ~abort;
      if (s2_vld_q) begin
        wr_addr_q <= base_q + wr_idx_q;
        wr_data_q <= s2_word_q;
      end
    end
  end

endmodule

// File: tb/tb_sequence_packer.sv
// Bench for sequence_packer: directed and randomized bursts against a field-level reference model.
// Expected words, addresses, write cycles and flags come from the model and the burst parameters.
module tb_sequence_packer;
  localparam int AW = 13;

  typedef struct packed {
    logic [15:0] d0, d1, p0, p1, p2, p3;
    logic [1:0]  en_dac, resync;
    logic [3:0]  en_pdm;
    logic [1:0]  ramp;
  } step_t;

  logic          clk = 1'b0;
  logic          areset, start, abort, s_valid, s_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_steps;
  logic [15:0]   s_dac_0, s_dac_1, s_pdm_0, s_pdm_1, s_pdm_2, s_pdm_3;
  logic [1:0]    s_enable_dac, s_resync_dac, s_ramp_down;
  logic [3:0]    s_enable_pdm;
  logic          wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [127:0]  wr_data;
  logic [5:0]    sat_flags;

  sequence_packer #(.ADDR_W(AW)) dut (
    .clk(clk), .areset(areset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_steps(num_steps),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_dac_0(s_dac_0), .s_dac_1(s_dac_1),
    .s_pdm_0(s_pdm_0), .s_pdm_1(s_pdm_1), .s_pdm_2(s_pdm_2), .s_pdm_3(s_pdm_3),
    .s_enable_dac(s_enable_dac), .s_resync_dac(s_resync_dac),
    .s_enable_pdm(s_enable_pdm), .s_ramp_down(s_ramp_down),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .sat_flags(sat_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [AW-1:0] got_addr_q[$], exp_addr_q[$];
  logic [127:0]  got_data_q[$], exp_data_q[$];
  int            got_cyc_q[$], exp_cyc_q[$], done_cyc_q[$];
  logic          done_busy_q[$];
  step_t         stim_q[$];

  logic [AW-1:0] cur_base;
  logic [AW:0]   cur_num;
  logic [5:0]    exp_sat;
  int            last_hs, accepted, s_cyc, a_cyc, n_late, nb;
  step_t         t;
  logic [AW-1:0] b2;
  int            wrap_exp[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write and done pulse with the edge index it appeared after.
  always @(negedge clk) begin
    if (wr_en) begin
      got_addr_q.push_back(wr_addr);
      got_data_q.push_back(wr_data);
      got_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cyc_q.push_back(cyc);
      done_busy_q.push_back(busy);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int m_dac(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s > 8191) s = 8191;
    else if (s < -8192) s = -8192;
    return s;
  endfunction

  function automatic int m_pdm(input logic [15:0] v);
    int u;
    u = int'(v);
    if (u > 2047) u = 2047;
    return u;
  endfunction

  function automatic logic [127:0] m_word(input step_t x);
    logic [127:0] w;
    w = '0;
    w |= 128'(m_dac(x.d0) & 32'h3FFF);
    w |= 128'(m_dac(x.d1) & 32'h3FFF) << 16;
    w |= 128'(x.resync) << 30;
    w |= 128'(m_pdm(x.p0)) << 32;
    w |= 128'(m_pdm(x.p1)) << 48;
    w |= 128'(m_pdm(x.p2)) << 64;
    w |= 128'(m_pdm(x.p3)) << 80;
    w |= 128'(x.en_dac) << 96;
    w |= 128'(x.en_pdm) << 98;
    w |= 128'(x.ramp[0]) << 112;
    w |= 128'(x.ramp[1]) << 113;
    return w;
  endfunction

  function automatic logic [5:0] m_sat(input step_t x);
    logic [5:0] s;
    s[0] = (m_dac(x.d0) != int'($signed(x.d0)));
    s[1] = (m_dac(x.d1) != int'($signed(x.d1)));
    s[2] = (m_pdm(x.p0) != int'(x.p0));
    s[3] = (m_pdm(x.p1) != int'(x.p1));
    s[4] = (m_pdm(x.p2) != int'(x.p2));
    s[5] = (m_pdm(x.p3) != int'(x.p3));
    return s;
  endfunction

  function automatic logic [15:0] r_dac();
    int sel, x;
    sel = int'($urandom_range(0, 2));
    case (sel)
      0: x = int'($urandom_range(0, 65535));
      1: x = int'($urandom_range(0, 16383)) - 8192;
      default: x = ($urandom_range(0, 1) == 1) ? 8191 + int'($urandom_range(0, 1))
                                                : -8192 - int'($urandom_range(0, 1));
    endcase
    return 16'(x);
  endfunction

  function automatic logic [15:0] r_pdm();
    int sel, x;
    sel = int'($urandom_range(0, 2));
    case (sel)
      0: x = int'($urandom_range(0, 65535));
      1: x = int'($urandom_range(0, 2047));
      default: x = 2047 + int'($urandom_range(0, 1));
    endcase
    return 16'(x);
  endfunction

  function automatic step_t rand_step();
    step_t x;
    x.d0 = r_dac(); x.d1 = r_dac();
    x.p0 = r_pdm(); x.p1 = r_pdm(); x.p2 = r_pdm(); x.p3 = r_pdm();
    x.en_dac = 2'($urandom); x.resync = 2'($urandom);
    x.en_pdm = 4'($urandom); x.ramp = 2'($urandom);
    return x;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input step_t x);
    s_dac_0 = x.d0; s_dac_1 = x.d1;
    s_pdm_0 = x.p0; s_pdm_1 = x.p1; s_pdm_2 = x.p2; s_pdm_3 = x.p3;
    s_enable_dac = x.en_dac; s_resync_dac = x.resync;
    s_enable_pdm = x.en_pdm; s_ramp_down = x.ramp;
  endtask

  task automatic clr();
    got_addr_q.delete(); got_data_q.delete(); got_cyc_q.delete();
    exp_addr_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
    done_cyc_q.delete(); done_busy_q.delete();
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] n);
    clr();
    cur_base = b; cur_num = n; exp_sat = '0;
    base_addr = b; num_steps = n; start = 1'b1;
    step();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  // mode 0: always valid, 1: random gaps, 2: valid pattern 1,0,1,1,..., 3: always valid plus a stray start
  task automatic drive(input string tag, input int mode, input int max_cycles);
    int k;
    logic rdy, v;
    k = 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (k >= stim_q.size()) break;
      case (mode)
        1: v = ($urandom_range(0, 99) >= 35);
        2: v = (c != 1);
        default: v = 1'b1;
      endcase
      start = (mode == 3 && c == 2);
      if (start) begin
        base_addr = cur_base + 13'd100;
        num_steps = 14'd2;
      end
      s_valid = v;
      apply(stim_q[k]);
      rdy = s_ready;
      step();
      start = 1'b0;
      if (v && rdy) begin
        exp_addr_q.push_back(AW'(int'(cur_base) + k));
        exp_data_q.push_back(m_word(stim_q[k]));
        exp_cyc_q.push_back(cyc + 2);
        exp_sat |= m_sat(stim_q[k]);
        last_hs = cyc;
        k++;
        if (k == int'(cur_num)) chk({tag, "_rdy_drop"}, 128'(s_ready), 128'(0));
      end
    end
    s_valid = 1'b0;
    accepted = k;
  endtask

  task automatic finish_burst(input string tag);
    repeat (8) step();
    chk({tag, "_nwr"}, 128'(got_addr_q.size()), 128'(exp_addr_q.size()));
    for (int i = 0; i < got_addr_q.size() && i < exp_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 128'(got_addr_q[i]), 128'(exp_addr_q[i]));
      chk($sformatf("%s_data%0d", tag, i), got_data_q[i], exp_data_q[i]);
      chk($sformatf("%s_wcyc%0d", tag, i), 128'(got_cyc_q[i]), 128'(exp_cyc_q[i]));
    end
    chk({tag, "_ndone"}, 128'(done_cyc_q.size()), 128'(1));
    if (done_cyc_q.size() > 0) begin
      chk({tag, "_done_cyc"}, 128'(done_cyc_q[0]), 128'(last_hs + 3));
      chk({tag, "_busy_at_done"}, 128'(done_busy_q[0]), 128'(0));
    end
    chk({tag, "_sat"}, 128'(sat_flags), 128'(exp_sat));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    areset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    base_addr = '0; num_steps = '0;
    t = '0;
    apply(t);
    wrap_exp[0] = 8190; wrap_exp[1] = 8191; wrap_exp[2] = 0; wrap_exp[3] = 1;
    repeat (2) step();
    chk("rst_s_ready", 128'(s_ready), 128'(0));
    chk("rst_wr_en", 128'(wr_en), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_wr_data", wr_data, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_sat", 128'(sat_flags), 128'(0));
    areset = 1'b0;
    step();

    // Single directed step
    t = '0;
    t.d0 = 16'h0123; t.d1 = 16'hFFFF;
    t.p0 = 16'd1; t.p1 = 16'd2; t.p2 = 16'd3; t.p3 = 16'd4;
    t.en_dac = 2'd3; t.resync = 2'd2; t.en_pdm = 4'hF; t.ramp = 2'b01;
    stim_q.delete(); stim_q.push_back(t);
    start_burst(13'h010, 14'd1);
    chk("single_busy_at_S", 128'(busy), 128'(1));
    chk("single_rdy_at_S", 128'(s_ready), 128'(1));
    drive("single", 0, 10);
    finish_burst("single");
    if (got_data_q.size() > 0)
      chk("single_word_const", got_data_q[0], 128'h0001003F_00040003_00020001_BFFF0123);

    // Saturation
    t = '0;
    t.d0 = 16'h7FFF; t.d1 = 16'h8000; t.p2 = 16'hFFFF;
    stim_q.delete(); stim_q.push_back(t);
    start_burst(13'h020, 14'd1);
    drive("sat", 0, 10);
    finish_burst("sat");
    chk("sat_flags_const", 128'(sat_flags), 128'(6'b010011));
    if (got_data_q.size() > 0)
      chk("sat_word_const", got_data_q[0], 128'h00000000_000007FF_00000000_20001FFF);

    // Random bursts with gaps; the first start also clears the flags left above
    for (int b = 0; b < 3; b++) begin
      nb = int'($urandom_range(5, 20));
      stim_q.delete();
      for (int i = 0; i < nb; i++) stim_q.push_back(rand_step());
      start_burst(13'($urandom), 14'(nb));
      if (b == 0) chk("sat_cleared_on_start", 128'(sat_flags), 128'(0));
      drive($sformatf("rnd%0d", b), 1, 4 * nb + 20);
      finish_burst($sformatf("rnd%0d", b));
    end

    // Wrap past the top address
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(rand_step());
    start_burst(13'd8190, 14'd4);
    drive("wrap", 0, 12);
    finish_burst("wrap");
    if (got_addr_q.size() == 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("wrap_const%0d", i), 128'(got_addr_q[i]), 128'(wrap_exp[i]));

    // Gaps in valid and a fourth step offered after the burst is full
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(rand_step());
    start_burst(13'($urandom), 14'd3);
    drive("bp", 2, 12);
    chk("bp_accepted", 128'(accepted), 128'(3));
    finish_burst("bp");

    // Start while busy is ignored
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(rand_step());
    start_burst(13'($urandom), 14'd6);
    drive("busystart", 3, 20);
    finish_burst("busystart");

    // Zero-length burst
    start_burst(13'($urandom), 14'd0);
    chk("zero_done_at_S", 128'(done), 128'(0));
    step();
    chk("zero_done_at_S1", 128'(done), 128'(1));
    step();
    chk("zero_done_at_S2", 128'(done), 128'(0));
    repeat (4) step();
    chk("zero_nwr", 128'(got_addr_q.size()), 128'(0));

    // New start accepted in the done cycle
    stim_q.delete(); stim_q.push_back(rand_step());
    start_burst(13'($urandom), 14'd1);
    drive("chain_a", 0, 10);
    for (int c = 0; c < 12; c++) begin
      step();
      if (done) break;
    end
    chk("chain_done_seen", 128'(done), 128'(1));
    @(negedge clk);
    #1;
    stim_q.delete(); stim_q.push_back(rand_step());
    b2 = 13'($urandom);
    start_burst(b2, 14'd1);
    chk("chain_busy", 128'(busy), 128'(1));
    chk("chain_rdy", 128'(s_ready), 128'(1));
    drive("chain_b", 0, 10);
    finish_burst("chain_b");

    // Abort one cycle after the second handshake
    stim_q.delete();
    for (int i = 0; i < 5; i++) stim_q.push_back(rand_step());
    start_burst(13'($urandom), 14'd5);
    s_valid = 1'b1; apply(stim_q[0]); step();
    apply(stim_q[1]); step();
    exp_sat = m_sat(stim_q[0]) | m_sat(stim_q[1]);
    s_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    a_cyc = cyc;
    chk("abort_wr_en", 128'(wr_en), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_rdy", 128'(s_ready), 128'(0));
    repeat (6) step();
    chk("abort_nwr_le1", 128'(got_addr_q.size() <= 1), 128'(1));
    n_late = 0;
    foreach (got_cyc_q[i]) if (got_cyc_q[i] >= a_cyc) n_late++;
    chk("abort_late_wr", 128'(n_late), 128'(0));
    chk("abort_no_done", 128'(done_cyc_q.size()), 128'(0));
    chk("abort_sat_kept", 128'(sat_flags), 128'(exp_sat));

    // Start and abort together: abort wins
    base_addr = 13'($urandom); num_steps = 14'd3;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 128'(busy), 128'(0));
    chk("sa_rdy", 128'(s_ready), 128'(0));
    chk("sa_sat_kept", 128'(sat_flags), 128'(exp_sat));

    // Asynchronous reset mid-burst
    stim_q.delete();
    for (int i = 0; i < 5; i++) stim_q.push_back(rand_step());
    start_burst(13'($urandom), 14'd5);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(stim_q[i]);
      step();
    end
    chk("arst_pre_wr_en", 128'(wr_en), 128'(1));
    #2;
    areset = 1'b1;
    #1;
    chk("arst_wr_en", 128'(wr_en), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_rdy", 128'(s_ready), 128'(0));
    chk("arst_wr_data", wr_data, 128'(0));
    chk("arst_wr_addr", 128'(wr_addr), 128'(0));
    chk("arst_sat", 128'(sat_flags), 128'(0));
    s_valid = 1'b0;
    repeat (2) step();
    areset = 1'b0;
    step();
    chk("arst_idle_after", 128'(busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
